mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_if.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester and downstream bundle for the round-robin packet mux
interface mux_rr_arbiter_if #(
  parameter int NUM_PORTS_WIDTH = 2,
  parameter int DATA_WIDTH      = 32
);
  localparam int N = 2**NUM_PORTS_WIDTH;

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last;
  logic [N*DATA_WIDTH-1:0] data_in;
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    out_last;
  logic [NUM_PORTS_WIDTH-1:0] out_port;

  // slave is the arbiter; master is the surrounding requesters plus the sink
  modport slave (
    input  in_valid, in_last, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last, out_port
  );

  modport master (
    output in_valid, in_last, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last, out_port
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - packet-locked round-robin mux with a registered output beat
module mux_rr_arbiter #(
  parameter int NUM_PORTS_WIDTH = 2,
  parameter int DATA_WIDTH      = 32
) (
  input  logic            clk,
  input  logic            rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int N = 2**NUM_PORTS_WIDTH;
  localparam logic [NUM_PORTS_WIDTH-1:0] ONE = 1;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e                     state_q, state_d;
  logic [NUM_PORTS_WIDTH-1:0] lock_port_q, lock_port_d;
  logic [NUM_PORTS_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_PORTS_WIDTH-1:0] out_port_q, out_port_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]      data_out_q, data_out_d;

  logic                       can_accept;
  logic                       grant_found;
  logic                       transfer;
  logic [NUM_PORTS_WIDTH-1:0] grant_idx, cand, sel;
  logic [N-1:0]               in_ready;

  assign can_accept = !out_valid_q || bus.out_ready;

  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = ptr_q + NUM_PORTS_WIDTH'(k);
      if (bus.in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel      = (state_q == LOCKED) ? lock_port_q : grant_idx;
    if (!rst && (state_q == LOCKED || grant_found)) begin
      in_ready[sel] = can_accept;
    end
    transfer = bus.in_valid[sel] && in_ready[sel];
  end

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_port_d  = out_port_q;
    data_out_d  = data_out_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_last_d  = bus.in_last[sel];
      out_port_d  = sel;
      data_out_d  = bus.data_in[sel*DATA_WIDTH +: DATA_WIDTH];
      if (bus.in_last[sel]) begin
        state_d = UNLOCKED;
        ptr_d   = sel + ONE;
      end else begin
        state_d     = LOCKED;
        lock_port_d = sel;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      lock_port_q <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_port_q  <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_port_q  <= out_port_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_port  = out_port_q;
  assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed vector bench for the round-robin packet mux
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.NUM_PORTS_WIDTH(2), .DATA_WIDTH(32)) bus ();

  mux_rr_arbiter #(.NUM_PORTS_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic       out_ready;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_port;
    logic       exp_last;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] pdata [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = r;
  endtask

  task automatic pre(input string name, input logic [3:0] exp_ready);
    #1;
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
  endtask

  task automatic post(input string name, input logic ev, input logic [1:0] ep,
                      input logic el, input logic [31:0] ed);
    @(posedge clk);
    #1;
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      check({name, ".out_port"}, 32'(bus.out_port), 32'(ep));
      check({name, ".out_last"}, 32'(bus.out_last), 32'(el));
      check({name, ".data_out"}, bus.data_out, ed);
    end
  endtask

  task automatic set_data();
    bus.data_in = {pdata[3], pdata[2], pdata[1], pdata[0]};
  endtask

  initial begin
    pdata[0] = 32'h0000_0011;
    pdata[1] = 32'h0000_0022;
    pdata[2] = 32'h0000_0033;
    pdata[3] = 32'h0000_0044;

    // all-last round robin from ptr=0
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    // move ptr to 2, then a 3-beat packet on port 2 while 0 and 1 request
    vecs[5]  = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[6]  = '{4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{4'b0111, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[9]  = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    // only port 3 valid: from ptr=1, then from ptr=0, then ptr wrapped to 0
    vecs[10] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[11] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    rst = 1'b1;
    set_data();
    drive(4'b1111, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    check("rst.in_ready",  32'(bus.in_ready),  32'h0);
    check("rst.out_valid", 32'(bus.out_valid), 32'h0);
    check("rst.out_port",  32'(bus.out_port),  32'h0);
    check("rst.out_last",  32'(bus.out_last),  32'h0);
    check("rst.data_out",  bus.data_out,       32'h0);
    @(posedge clk);
    #1;
    check("rst2.out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].in_valid, vecs[i].in_last, vecs[i].out_ready);
      pre(nm, vecs[i].exp_ready);
      post(nm, vecs[i].exp_valid, vecs[i].exp_port, vecs[i].exp_last,
           pdata[vecs[i].exp_port]);
    end

    // backpressure: DEADBEEF from port 0 held for 5 stalled cycles (ptr=1 here)
    pdata[0] = 32'hDEADBEEF;
    set_data();
    drive(4'b0001, 4'b1111, 1'b1);
    pre("bp_load", 4'b0001);
    post("bp_load", 1'b1, 2'd0, 1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("bp_stall%0d", i);
      drive(4'b1111, 4'b1111, 1'b0);
      pre(nm, 4'b0000);
      post(nm, 1'b1, 2'd0, 1'b1, 32'hDEADBEEF);
    end
    drive(4'b1111, 4'b1111, 1'b1);
    pre("bp_release", 4'b0010);
    post("bp_release", 1'b1, 2'd1, 1'b1, pdata[1]);

    // lock on port 1 (ptr=2), port 1 idles while port 3 requests
    drive(4'b0010, 4'b0000, 1'b1);
    pre("lk_first", 4'b0010);
    post("lk_first", 1'b1, 2'd1, 1'b0, pdata[1]);
    for (int i = 0; i < 3; i++) begin
      string nm;
      nm = $sformatf("lk_bubble%0d", i);
      drive(4'b1000, 4'b1000, 1'b1);
      pre(nm, 4'b0010);
      post(nm, 1'b0, 2'd0, 1'b0, 32'h0);
    end
    drive(4'b1010, 4'b1010, 1'b1);
    pre("lk_resume", 4'b0010);
    post("lk_resume", 1'b1, 2'd1, 1'b1, pdata[1]);

    // reset in the middle of a port 3 packet (ptr=2)
    drive(4'b1000, 4'b0000, 1'b1);
    pre("mr_start", 4'b1000);
    post("mr_start", 1'b1, 2'd3, 1'b0, pdata[3]);
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    pre("mr_rst", 4'b0000);
    @(posedge clk);
    #1;
    check("mr_rst.out_valid", 32'(bus.out_valid), 32'h0);
    check("mr_rst.out_port",  32'(bus.out_port),  32'h0);
    check("mr_rst.data_out",  bus.data_out,       32'h0);
    rst = 1'b0;
    pre("mr_after", 4'b0001);
    post("mr_after", 1'b1, 2'd0, 1'b1, pdata[0]);
    drive(4'b1111, 4'b1111, 1'b1);
    pre("mr_next", 4'b0010);
    post("mr_next", 1'b1, 2'd1, 1'b1, pdata[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
